rvfi_imem_fetch_arbiter: RTL and testbench



---
 rtl/rvfi_imem_fetch_arbiter_pkg.sv | 47 ++++
 rtl/rvfi_imem_fetch_arbiter_if.sv | 31 +++
 rtl/rvfi_rr_pick.sv | 37 +++
 rtl/rvfi_imem_fetch_arbiter.sv | 143 ++++++++++++++
 tb/tb_rvfi_imem_fetch_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rvfi_imem_fetch_arbiter_pkg.sv
// Purpose : shared types, constants and the rotating-priority helper for the imem fetch arbiter.
// Latency : n/a (declarations and a combinational function only).
// Backpressure : n/a.
// Contents: state_e (3-bit FSM encoding), HALF_BYTES, RR_MAX, rr_onehot().
package rvfi_imem_fetch_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LO_REQ  = 3'd1,
    ST_LO_WAIT = 3'd2,
    ST_HI_REQ  = 3'd3,
    ST_HI_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  // Byte distance between the two halfwords of a 32-bit fetch.
  localparam int HALF_BYTES = 2;

  // Widest requester vector the round-robin helper supports.
  localparam int RR_MAX = 8;

  // Rotating-priority select: scan ptr, ptr+1, ... (mod n) and return the
  // first requesting position as a one-hot vector (all zero if none).
  // Only the low n bits of req are considered.
  function automatic logic [RR_MAX-1:0] rr_onehot(
    input logic [RR_MAX-1:0] req,
    input logic [2:0]        ptr,
    input int unsigned       n
  );
    logic [RR_MAX-1:0] gnt;
    logic              found;
    int unsigned       idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      idx = 32'(ptr) + k;
      // ptr < n and k < n, so a single subtraction is a full modulo.
      if (idx >= n) idx = idx - n;
      if (!found && (k < n) && (idx < RR_MAX) && req[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rvfi_imem_fetch_arbiter_if.sv
// Purpose : requester-side and memory-side handshake bundle of the imem fetch arbiter.
// Latency : n/a (wires only).
// Backpressure : requesters wait on req_ready; memory stalls requests with mem_ready.
// Ports   : slave = arbiter view, master = requesters + memory model view.
interface rvfi_imem_fetch_arbiter_if #(
  parameter int XLEN = 32,
  parameter int NREQ = 2
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*XLEN-1:0] req_addr;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [31:0]          rsp_insn;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [XLEN-1:0]      mem_addr;
  logic                 mem_rvalid;
  logic [15:0]          mem_rdata;

  modport slave (
    input  req_valid, req_addr, mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_insn, mem_valid, mem_addr
  );

  modport master (
    output req_valid, req_addr, mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_insn, mem_valid, mem_addr
  );

endinterface

// File: rtl/rvfi_rr_pick.sv
// Purpose : combinational round-robin picker, priority starting at i_ptr.
// Latency : 0 cycles (pure combinational).
// Backpressure : none; the caller decides whether to act on o_gnt.
// Ports   : i_req request vector, i_ptr start index, o_gnt one-hot grant, o_idx grant index, o_any.
module rvfi_rr_pick
  import rvfi_imem_fetch_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  logic [RR_MAX-1:0] w_req_ext;
  logic [RR_MAX-1:0] w_gnt_ext;
  logic [2:0]        w_ptr_ext;

  assign w_req_ext = RR_MAX'(i_req);
  assign w_ptr_ext = 3'(i_ptr);
  assign w_gnt_ext = rr_onehot(w_req_ext, w_ptr_ext, 32'(NREQ));

  assign o_gnt = w_gnt_ext[NREQ-1:0];
  assign o_any = |w_gnt_ext;

  // One-hot to binary; at most one bit is set.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_ext[i]) o_idx = IDXW'(i);
    end
  end

endmodule

// File: rtl/rvfi_imem_fetch_arbiter.sv
// Purpose : shares one 16-bit halfword imem port among NREQ 32-bit instruction fetchers.
// Latency : accept -> rsp_valid 5 cycles minimum (3 for a compressed low half when
//           RISCV_FORMAL_IMEM_ARB_COMPRESSED_EN is defined).
// Backpressure : requests accepted only in IDLE; mem_valid/mem_addr held until mem_ready;
//                responses are a one-cycle pulse with no backpressure.
// Ports   : clk, reset (sync, active-high), bus (slave modport of rvfi_imem_fetch_arbiter_if).
// Options : RISCV_FORMAL_IMEM_ARB_COMPRESSED_EN - finish after one read when the low
//           halfword is a compressed encoding (bits [1:0] != 2'b11).
module rvfi_imem_fetch_arbiter
  import rvfi_imem_fetch_arbiter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  rvfi_imem_fetch_arbiter_if.slave  bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [IDXW-1:0] r_rr_ptr;
  logic [IDXW-1:0] r_gidx;
  logic [XLEN-1:0] r_base;
  logic [15:0]     r_lo;
  logic [31:0]     r_insn;

  logic [NREQ-1:0] w_pick_gnt;
  logic [IDXW-1:0] w_pick_idx;
  logic            w_pick_any;
  logic            w_grant;
  logic [IDXW-1:0] w_ptr_nxt;
  logic [XLEN-1:0] w_req_addr_g;
  logic [XLEN-1:0] w_hi_addr;
  logic            w_lo_take;
  logic            w_hi_take;
  logic            w_lo_short;

  rvfi_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_req_addr_g = bus.req_addr[w_pick_idx*XLEN +: XLEN];
  // Upper halfword address wraps naturally at 2^XLEN.
  assign w_hi_addr    = r_base + XLEN'(HALF_BYTES);
  assign w_ptr_nxt    = (w_pick_idx == IDXW'(NREQ - 1)) ? '0 : w_pick_idx + IDXW'(1);

  assign w_lo_take = (r_state == ST_LO_WAIT) && bus.mem_rvalid;
  assign w_hi_take = (r_state == ST_HI_WAIT) && bus.mem_rvalid;

`ifdef RISCV_FORMAL_IMEM_ARB_COMPRESSED_EN
  assign w_lo_short = (bus.mem_rdata[1:0] != 2'b11);
`else
  assign w_lo_short = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and outputs. Outputs decode from the current state so that
  // mem_valid/mem_addr stay constant while a memory request is stalled.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_insn  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    case (r_state)
      ST_IDLE: begin
        // No accept pulse while reset is held: the grant would be discarded.
        if (w_pick_any && !reset) begin
          w_grant       = 1'b1;
          bus.req_ready = w_pick_gnt;
          w_state_nxt   = ST_LO_REQ;
        end
      end
      ST_LO_REQ: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = r_base;
        if (bus.mem_ready) w_state_nxt = ST_LO_WAIT;
      end
      ST_LO_WAIT: begin
        if (bus.mem_rvalid) w_state_nxt = w_lo_short ? ST_RESP : ST_HI_REQ;
      end
      ST_HI_REQ: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = w_hi_addr;
        if (bus.mem_ready) w_state_nxt = ST_HI_WAIT;
      end
      ST_HI_WAIT: begin
        if (bus.mem_rvalid) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = NREQ'(1) << r_gidx;
        bus.rsp_insn  = r_insn;
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping and instruction assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_gidx   <= '0;
      r_base   <= '0;
      r_lo     <= '0;
      r_insn   <= '0;
    end else begin
      if (w_grant) begin
        r_gidx   <= w_pick_idx;
        r_base   <= w_req_addr_g & ~XLEN'(1);
        r_rr_ptr <= w_ptr_nxt;
      end
      if (w_lo_take) begin
        r_lo <= bus.mem_rdata;
        if (w_lo_short) r_insn <= {16'h0000, bus.mem_rdata};
      end
      if (w_hi_take) begin
        r_insn <= {bus.mem_rdata, r_lo};
      end
    end
  end

endmodule

// File: tb/tb_rvfi_imem_fetch_arbiter.sv
// Purpose : directed self-checking bench for rvfi_imem_fetch_arbiter (NREQ=2, XLEN=32).
// Latency : memory model answers one cycle after each accepted halfword request.
// Backpressure : mem_ready is driven directly by the stimulus sequence.
module tb_rvfi_imem_fetch_arbiter;
  import rvfi_imem_fetch_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rvfi_imem_fetch_arbiter_if #(.XLEN(32), .NREQ(2)) bus ();

  rvfi_imem_fetch_arbiter #(.XLEN(32), .NREQ(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: fixed halfword image, one-cycle read latency.
  logic        m_rvalid;
  logic [15:0] m_rdata;
  logic        spur;
  logic [31:0] log_q[$];

  function automatic logic [15:0] image(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 16'h0013;
      32'h0000_1002: return 16'h0000;
      32'h0000_0100: return 16'h0513;
      32'h0000_0102: return 16'h00A0;
      32'h0000_0200: return 16'h0593;
      32'h0000_0202: return 16'h0140;
      32'hFFFF_FFFE: return 16'h5677;
      32'h0000_0000: return 16'hABCD;
      32'h0000_0300: return 16'h4501;
      32'h0000_0302: return 16'h8082;
      default:       return 16'hDEAD;
    endcase
  endfunction

  assign bus.mem_rvalid = m_rvalid | spur;
  assign bus.mem_rdata  = m_rdata;

  always @(posedge clk) begin
    if (reset) begin
      m_rvalid <= 1'b0;
      m_rdata  <= 16'h0;
    end else begin
      m_rvalid <= bus.mem_valid && bus.mem_ready;
      if (bus.mem_valid && bus.mem_ready) begin
        m_rdata <= image(bus.mem_addr);
        log_q.push_back(bus.mem_addr);
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [1:0] exp);
    int n = 0;
    while (bus.req_ready == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(bus.req_ready), 64'(exp));
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] exp_v, input logic [31:0] exp_insn);
    int n = 0;
    while (bus.rsp_valid == 2'b00 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, 64'(bus.rsp_valid), 64'(exp_v));
    chk({tag, "_insn"}, 64'(bus.rsp_insn), 64'(exp_insn));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    bus.req_valid = 2'b00;
    bus.req_addr  = '0;
    bus.mem_ready = 1'b1;
    spur          = 1'b0;
    reset         = 1'b1;
    tick();
    tick();

    // Reset values
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_rsp_insn",  64'(bus.rsp_insn),  64'h0);
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'h0);
    chk("rst_mem_addr",  64'(bus.mem_addr),  64'h0);
    reset = 1'b0;
    tick();

    // 1: single fetch, cycle-exact timeline
    bus.req_valid      = 2'b01;
    bus.req_addr[31:0] = 32'h0000_1001;
    #1;
    chk("t1_gnt", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b00;
    chk("t1_lo_vld",  64'(bus.mem_valid), 64'h1);
    chk("t1_lo_addr", 64'(bus.mem_addr),  64'h1000);
    tick();
    chk("t1_wait_vld", 64'(bus.mem_valid), 64'h0);
    tick();
    chk("t1_hi_vld",  64'(bus.mem_valid), 64'h1);
    chk("t1_hi_addr", 64'(bus.mem_addr),  64'h1002);
    tick();
    chk("t1_no_rsp_early", 64'(bus.rsp_valid), 64'h0);
    tick();
    chk("t1_rsp_vld",  64'(bus.rsp_valid), 64'h1);
    chk("t1_rsp_insn", 64'(bus.rsp_insn),  64'h0000_0013);
    tick();
    chk("t1_rsp_pulse", 64'(bus.rsp_valid), 64'h0);

    // 2: both held valid, grants alternate 0,1,0,1 from a fresh pointer
    do_reset();
    bus.req_valid       = 2'b11;
    bus.req_addr[31:0]  = 32'h0000_0100;
    bus.req_addr[63:32] = 32'h0000_0200;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_req("t2_gnt", (k % 2 == 0) ? 2'b01 : 2'b10);
      wait_rsp("t2_rsp", (k % 2 == 0) ? 2'b01 : 2'b10,
               (k % 2 == 0) ? 32'h00A0_0513 : 32'h0140_0593);
      tick();
    end
    bus.req_valid = 2'b00;
    tick();

    // 3: memory stall in LO_REQ with a spurious rvalid
    log_q.delete();
    bus.mem_ready      = 1'b0;
    bus.req_valid      = 2'b01;
    bus.req_addr[31:0] = 32'h0000_1001;
    #1;
    chk("t3_gnt", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b00;
    for (int s = 0; s < 4; s++) begin
      chk("t3_hold_vld",  64'(bus.mem_valid), 64'h1);
      chk("t3_hold_addr", 64'(bus.mem_addr),  64'h1000);
      spur = (s == 1);
      if (s == 3) bus.mem_ready = 1'b1;
      if (s < 3) tick();
    end
    wait_rsp("t3_rsp", 2'b01, 32'h0000_0013);
    chk("t3_reads", 64'(log_q.size()), 64'd2);
    tick();

    // 4: upper halfword address wraps (pointer now at 1)
    log_q.delete();
    bus.req_valid       = 2'b10;
    bus.req_addr[63:32] = 32'hFFFF_FFFE;
    #1;
    chk("t4_gnt", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp("t4_rsp", 2'b10, 32'hABCD_5677);
    chk("t4_reads", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("t4_addr_lo", 64'(log_q[0]), 64'hFFFF_FFFE);
      chk("t4_addr_hi", 64'(log_q[1]), 64'h0000_0000);
    end
    tick();

    // 5: compressed low halfword
    log_q.delete();
    bus.req_valid      = 2'b01;
    bus.req_addr[31:0] = 32'h0000_0300;
    #1;
    wait_req("t5_gnt", 2'b01);
    tick();
    bus.req_valid = 2'b00;
`ifdef RISCV_FORMAL_IMEM_ARB_COMPRESSED_EN
    wait_rsp("t5_rsp", 2'b01, 32'h0000_4501);
    chk("t5_reads", 64'(log_q.size()), 64'd1);
`else
    wait_rsp("t5_rsp", 2'b01, 32'h8082_4501);
    chk("t5_reads", 64'(log_q.size()), 64'd2);
`endif
    tick();

    // 6: reset in HI_WAIT aborts the fetch and clears the pointer
    bus.req_valid      = 2'b01;
    bus.req_addr[31:0] = 32'h0000_1000;
    #1;
    wait_req("t6_gnt", 2'b01);
    tick();
    bus.req_valid = 2'b00;
    n = 0;
    while (!(bus.mem_valid && bus.mem_addr == 32'h0000_1002) && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("t6_in_hi_wait", 64'(dut.r_state), 64'(ST_HI_WAIT));
    reset = 1'b1;
    tick();
    chk("t6_rst_state",     64'(dut.r_state),   64'(ST_IDLE));
    chk("t6_rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("t6_rst_rsp_insn",  64'(bus.rsp_insn),  64'h0);
    chk("t6_rst_mem_valid", 64'(bus.mem_valid), 64'h0);
    chk("t6_rst_mem_addr",  64'(bus.mem_addr),  64'h0);
    chk("t6_rst_req_ready", 64'(bus.req_ready), 64'h0);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.rsp_valid != 2'b00) seen++;
    end
    chk("t6_no_aborted_rsp", 64'(seen), 64'd0);
    bus.req_valid       = 2'b11;
    bus.req_addr[31:0]  = 32'h0000_0100;
    bus.req_addr[63:32] = 32'h0000_0200;
    #1;
    chk("t6_gnt_from_0", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp("t6_rsp", 2'b01, 32'h00A0_0513);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
